aer_spike_encoder: RTL and testbench
====================================

# aer_spike_encoder

Rate-coding front end placed directly upstream of the ODIN_ffstdp core. Holds one 784-pixel 8-bit image in a local buffer. For each of T_STEPS time steps it compares every pixel against a 16-bit LFSR sample and emits one AER spike event per firing pixel on the core's AERIN 4-phase handshake. Each time step ends with a tick event.

## Interface
Parameters:
- N, 784, number of input pixels / input neurons
- M, 12, pixel index width; AER address is M+2 bits
- PIX_W, 8, pixel intensity width
- T_STEPS, 16, time steps per image (≥1)
- LFSR_SEED, 16'hACE1, LFSR value after reset (non-zero)

Ports:
- CLK  in  1  system clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- IMG_WE  in  1  pixel write strobe; ignored while BUSY=1
- IMG_WADDR  in  M  pixel index; writes with index ≥ N are dropped
- IMG_WDATA  in  PIX_W  pixel intensity
- START  in  1  single-cycle pulse that begins encoding; ignored while BUSY=1
- BUSY  out  1  high from the cycle after an accepted START until DONE
- DONE  out  1  one-cycle pulse after the last tick handshake completes
- EVT_CNT  out  16  spike events sent for the current image; saturates at 16'hFFFF
- AERIN_ADDR  out  M+2  event address {type[1:0], idx[M-1:0]}
- AERIN_REQ  out  1  4-phase request
- AERIN_ACK  in  1  4-phase acknowledge

## Operation
- Address types:
  - 2'b00 = spike, idx = pixel index.
  - 2'b01 = tick, idx = 0.
  - Types 2'b10 and 2'b11 are never emitted.
- LFSR:
  - 16-bit Galois, taps x^16+x^14+x^13+x^11+1.
  - Advances exactly once per pixel evaluation.
  - Not reseeded by START, only by reset.
- Spike rule: pixel fires iff lfsr[7:0] < pixel, using the LFSR value before it advances.
  - Pixel 0 never fires.
  - Pixel 255 fires unless lfsr[7:0]=255.
- FSM states:
  - IDLE: START → FETCH; clear EVT_CNT, step=0, idx=0.
  - FETCH: issue buffer read for idx (1-cycle read latency) → EVAL.
  - EVAL: apply spike rule and advance LFSR. Fire → REQ_HI with ADDR={00,idx} and REQ=1. No fire → NEXT.
  - REQ_HI: wait for synchronized ACK=1; then REQ=0 and increment EVT_CNT for spikes → REQ_LO.
  - REQ_LO: wait for synchronized ACK=0 → NEXT for a spike, → STEP_END for a tick.
  - NEXT: if idx=N-1 then TICK, else idx+1 → FETCH.
  - TICK: ADDR={01,0}, REQ=1 → REQ_HI.
  - STEP_END: if step=T_STEPS-1, pulse DONE → IDLE; else step+1, idx=0 → FETCH.
- AERIN_ADDR is held stable from REQ rise until REQ fall.
- Reset values: AERIN_REQ=0, AERIN_ADDR=0, BUSY=0, DONE=0, EVT_CNT=0, LFSR=LFSR_SEED, FSM=IDLE. Buffer contents are undefined after reset.

## Timing
- AERIN_ACK passes through a 2-flop synchronizer.
  - ACK rising at edge k → REQ falls at edge k+3.
  - The same 3-cycle delay applies to ACK fall before the next FETCH.
- START accepted at edge 0: BUSY=1 after edge 1. First pixel is evaluated at edge 3, so the earliest REQ rise is after edge 3.
- A non-firing pixel costs 3 cycles (FETCH, EVAL, NEXT).
- ACK stuck high or low: FSM waits indefinitely in REQ_HI or REQ_LO. No timeout.
- ACK high while REQ=0 (protocol error): ignored. Completion is only counted in REQ_HI.
- RST_N low mid-handshake: REQ drops immediately (asynchronous). After release the FSM is in IDLE and BUSY=0.
- START and IMG_WE in the same IDLE cycle: the write completes and the run starts. The written pixel is visible to the run.
- DONE is never asserted together with REQ.

## Structure
- Package aer_enc_pkg:
  - AER type constants AER_SPIKE=2'b00, AER_TICK=2'b01.
  - FSM state enum.
  - LFSR tap mask and LFSR_SEED default.
- Sub-module pixel_buf: N×PIX_W simple dual-port RAM, 1 write port, 1 registered read port. Infers BRAM.
- LFSR, synchronizer, FSM and counters live in the top.

## Test plan
- All-zero image, T_STEPS=4, ACK responder with 1-cycle delay → exactly 4 events, each AERIN_ADDR={01,0}; EVT_CNT=0; one DONE pulse.
- Single pixel idx=5 at 255, rest 0, T_STEPS=16 → only spike address {00,5} plus ticks. Spike count per step matches the bit-accurate LFSR model; EVT_CNT equals the model total.
- Random image checked against the reference model with LFSR_SEED → identical event sequence and order, including the tick positions after idx 783.
- Responder holds ACK low for 50 cycles → REQ and ADDR stay stable; no further events. Random ACK delays of 0–20 cycles → sequence unchanged.
- RST_N pulsed low while REQ=1 → REQ=0 in the same cycle; BUSY=0; LFSR equals LFSR_SEED; a new START reproduces the full sequence from the start.
- START and IMG_WE while BUSY=1 → ignored. Buffer unchanged, verified by a rerun after DONE. Write to IMG_WADDR=784 → dropped.

Source files
------------

// File: rtl/aer_enc_pkg.sv
// Shared constants, FSM encoding and LFSR helper for the AER rate-coding encoder.
package aer_enc_pkg;

  localparam logic [1:0]  AER_SPIKE         = 2'b00;
  localparam logic [1:0]  AER_TICK          = 2'b01;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EVAL,
    S_REQ_HI,
    S_REQ_LO,
    S_NEXT,
    S_TICK,
    S_STEP_END
  } enc_state_e;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

endpackage

// File: rtl/aer_spike_encoder_pixel_buf.sv
// Image buffer: simple dual-port RAM, one write port, registered read (1-cycle latency).
// Out-of-range write addresses are dropped; contents are not reset.
module pixel_buf
  import aer_enc_pkg::*;
#(
  parameter int N     = 784,
  parameter int M     = 12,
  parameter int PIX_W = 8,
  parameter int AW    = $clog2(N)
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [M-1:0]     wr_addr_i,
  input  logic [PIX_W-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [PIX_W-1:0] rd_data_o
);

  logic [PIX_W-1:0] mem_q [N];
  logic [PIX_W-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i && (wr_addr_i < M'(N))) begin
      mem_q[wr_addr_i[AW-1:0]] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/aer_spike_encoder.sv
// Rate-coding AER front end: compares each buffered pixel against an LFSR sample per time step
// and emits spike/tick events on a 4-phase REQ/ACK handshake; stalls indefinitely on ACK.
module aer_spike_encoder
  import aer_enc_pkg::*;
#(
  parameter int          N         = 784,
  parameter int          M         = 12,
  parameter int          PIX_W     = 8,
  parameter int          T_STEPS   = 16,
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IMG_WE,
  input  logic [M-1:0]     IMG_WADDR,
  input  logic [PIX_W-1:0] IMG_WDATA,
  input  logic             START,
  output logic             BUSY,
  output logic             DONE,
  output logic [15:0]      EVT_CNT,
  output logic [M+1:0]     AERIN_ADDR,
  output logic             AERIN_REQ,
  input  logic             AERIN_ACK
);

  localparam int AW = $clog2(N);
  localparam int SW = (T_STEPS > 1) ? $clog2(T_STEPS) : 1;

  enc_state_e      state_q, state_d;
  logic [M-1:0]    idx_q, idx_d;
  logic [SW-1:0]   step_q, step_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [M+1:0]    addr_q, addr_d;
  logic            req_q, req_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            done_q, done_d;
  logic            start_q;
  logic            ack_s1_q, ack_s2_q;
  logic [PIX_W-1:0] pix_dat;
  logic            idle;

  assign idle = (state_q == S_IDLE);

  pixel_buf #(
    .N     (N),
    .M     (M),
    .PIX_W (PIX_W),
    .AW    (AW)
  ) u_buf (
    .clk_i     (CLK),
    .wr_en_i   (IMG_WE && idle),
    .wr_addr_i (IMG_WADDR),
    .wr_data_i (IMG_WDATA),
    .rd_en_i   (state_q == S_FETCH),
    .rd_addr_i (idx_q[AW-1:0]),
    .rd_data_o (pix_dat)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      step_q   <= '0;
      lfsr_q   <= LFSR_SEED;
      addr_q   <= '0;
      req_q    <= 1'b0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      start_q  <= 1'b0;
      ack_s1_q <= 1'b0;
      ack_s2_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      step_q   <= step_d;
      lfsr_q   <= lfsr_d;
      addr_q   <= addr_d;
      req_q    <= req_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      // START is registered so a same-cycle pixel write lands before the first read
      start_q  <= START && idle;
      ack_s1_q <= AERIN_ACK;
      ack_s2_q <= ack_s1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    step_d  = step_q;
    lfsr_d  = lfsr_q;
    addr_d  = addr_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_q) begin
          cnt_d   = '0;
          step_d  = '0;
          idx_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_EVAL;
      S_EVAL: begin
        lfsr_d = lfsr_step(lfsr_q);
        if (lfsr_q[7:0] < pix_dat) begin
          addr_d  = {AER_SPIKE, idx_q};
          req_d   = 1'b1;
          state_d = S_REQ_HI;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_REQ_HI: begin
        if (ack_s2_q) begin
          req_d = 1'b0;
          if ((addr_q[M+1:M] == AER_SPIKE) && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
          end
          state_d = S_REQ_LO;
        end
      end
      S_REQ_LO: begin
        if (!ack_s2_q) begin
          state_d = (addr_q[M+1:M] == AER_TICK) ? S_STEP_END : S_NEXT;
        end
      end
      S_NEXT: begin
        if (idx_q == M'(N - 1)) begin
          state_d = S_TICK;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_TICK: begin
        addr_d  = {AER_TICK, {M{1'b0}}};
        req_d   = 1'b1;
        state_d = S_REQ_HI;
      end
      S_STEP_END: begin
        if (step_q == SW'(T_STEPS - 1)) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          step_d  = step_q + 1'b1;
          idx_d   = '0;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign BUSY       = !idle;
  assign DONE       = done_q;
  assign EVT_CNT    = cnt_q;
  assign AERIN_ADDR = addr_q;
  assign AERIN_REQ  = req_q;

endmodule

// File: tb/tb_aer_spike_encoder.sv
// Directed bench for aer_spike_encoder: ACK responder, event monitor and a bit-accurate LFSR model.
module tb_aer_spike_encoder;

  localparam int          N       = 784;
  localparam int          M       = 12;
  localparam int          PIX_W   = 8;
  localparam int          T_STEPS = 2;
  localparam logic [15:0] SEED    = 16'hACE1;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             IMG_WE = 1'b0;
  logic [M-1:0]     IMG_WADDR = '0;
  logic [PIX_W-1:0] IMG_WDATA = '0;
  logic             START = 1'b0;
  logic             AERIN_ACK = 1'b0;
  logic             BUSY, DONE, AERIN_REQ;
  logic [15:0]      EVT_CNT;
  logic [M+1:0]     AERIN_ADDR;

  int errors = 0;
  int checks = 0;

  aer_spike_encoder #(
    .N(N), .M(M), .PIX_W(PIX_W), .T_STEPS(T_STEPS), .LFSR_SEED(SEED)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .IMG_WE(IMG_WE), .IMG_WADDR(IMG_WADDR),
    .IMG_WDATA(IMG_WDATA), .START(START), .BUSY(BUSY), .DONE(DONE),
    .EVT_CNT(EVT_CNT), .AERIN_ADDR(AERIN_ADDR), .AERIN_REQ(AERIN_REQ),
    .AERIN_ACK(AERIN_ACK)
  );

  always #5 CLK = ~CLK;

  // 4-phase responder
  bit resp_en  = 1'b1;
  bit ack_rand = 1'b0;
  int ack_dly  = 1;
  always begin
    int d;
    @(negedge CLK);
    d = ack_rand ? int'($urandom_range(20, 0)) : ack_dly;
    if (resp_en && AERIN_REQ && !AERIN_ACK) begin
      repeat (d) @(negedge CLK);
      AERIN_ACK = 1'b1;
    end else if (AERIN_ACK && !AERIN_REQ) begin
      repeat (d) @(negedge CLK);
      AERIN_ACK = 1'b0;
    end
  end

  // Event monitor
  logic [M+1:0] got [$];
  logic         req_prev  = 1'b0;
  logic [M+1:0] hold_addr = '0;
  int           stab_err = 0, done_cnt = 0, done_req_err = 0;
  always @(negedge CLK) begin
    if (AERIN_REQ && !req_prev) got.push_back(AERIN_ADDR);
    if (AERIN_REQ && req_prev && (AERIN_ADDR !== hold_addr)) stab_err <= stab_err + 1;
    if (DONE) done_cnt <= done_cnt + 1;
    if (DONE && AERIN_REQ) done_req_err <= done_req_err + 1;
    req_prev  <= AERIN_REQ;
    hold_addr <= AERIN_ADDR;
  end

  // Reference model
  logic [7:0]   img [N];
  logic [M+1:0] exp_q [$];
  logic [15:0]  mdl_lfsr = SEED;
  int           exp_spk, base_ev, base_done;

  function automatic logic [15:0] mdl_next(input logic [15:0] v);
    logic [15:0] r;
    r = {1'b0, v[15:1]};
    if (v[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  task automatic build_expected();
    exp_q.delete();
    exp_spk = 0;
    for (int s = 0; s < T_STEPS; s++) begin
      for (int i = 0; i < N; i++) begin
        if (mdl_lfsr[7:0] < img[i]) begin
          exp_q.push_back({2'b00, M'(i)});
          exp_spk++;
        end
        mdl_lfsr = mdl_next(mdl_lfsr);
      end
      exp_q.push_back({2'b01, {M{1'b0}}});
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wr(input int a, input int v);
    IMG_WE = 1'b1; IMG_WADDR = M'(a); IMG_WDATA = 8'(v);
    @(negedge CLK);
    IMG_WE = 1'b0;
    if (a < N) img[a] = 8'(v);
  endtask

  task automatic begin_run(input bit we, input int wa, input int wv);
    if (we && wa < N) img[wa] = 8'(wv);
    build_expected();
    base_ev   = got.size();
    base_done = done_cnt;
    IMG_WE = we; IMG_WADDR = M'(wa); IMG_WDATA = 8'(wv); START = 1'b1;
    @(negedge CLK);
    IMG_WE = 1'b0; START = 1'b0;
  endtask

  task automatic end_run(input string tag);
    bit seen = 1'b0;
    for (int c = 0; c < 30000; c++) begin
      @(negedge CLK);
      if (DONE) begin seen = 1'b1; break; end
    end
    chk({tag, " done_seen"}, 32'(seen), 32'd1);
    @(negedge CLK); @(negedge CLK);
    chk({tag, " busy_after"}, 32'(BUSY), 32'd0);
    chk({tag, " done_pulses"}, 32'(done_cnt - base_done), 32'd1);
    chk({tag, " evt_cnt"}, 32'(EVT_CNT), 32'(exp_spk));
    chk({tag, " n_events"}, 32'(got.size() - base_ev), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base_ev + i < got.size())
        chk($sformatf("%s ev%0d", tag, i), 32'(got[base_ev + i]), 32'(exp_q[i]));
    end
  endtask

  initial begin
    bit          seen, stable;
    logic [M+1:0] a0;

    repeat (3) @(negedge CLK);
    chk("rst req",  32'(AERIN_REQ),  32'd0);
    chk("rst addr", 32'(AERIN_ADDR), 32'd0);
    chk("rst busy", 32'(BUSY),       32'd0);
    chk("rst done", 32'(DONE),       32'd0);
    chk("rst cnt",  32'(EVT_CNT),    32'd0);
    RST_N = 1'b1;
    @(negedge CLK);

    // All-zero image: only ticks
    for (int i = 0; i < N; i++) wr(i, 0);
    begin_run(1'b0, 0, 0);
    chk("start busy e0", 32'(BUSY), 32'd0);
    @(negedge CLK);
    chk("start busy e1", 32'(BUSY), 32'd1);
    end_run("zero");

    // Pixel 5 = 255 written in the same cycle as START
    begin_run(1'b1, 5, 255);
    end_run("single");

    // Sparse random image; out-of-range writes must be dropped
    wr(784, 77);
    wr(1029, 99);
    for (int k = 0; k < 30; k++) wr(int'($urandom_range(N - 1, 0)), int'($urandom_range(255, 1)));
    wr(0, 200);
    wr(5, 180);
    wr(783, 255);
    ack_rand = 1'b1;
    begin_run(1'b0, 0, 0);
    @(negedge CLK); @(negedge CLK);
    IMG_WE = 1'b1; IMG_WADDR = M'(5); IMG_WDATA = ~img[5]; START = 1'b1;
    @(negedge CLK);
    IMG_WE = 1'b0; START = 1'b0;
    end_run("rand");

    // Rerun: buffer must be unchanged by the writes attempted while busy
    ack_rand = 1'b0;
    ack_dly  = 0;
    begin_run(1'b0, 0, 0);
    end_run("rerun");

    // Stalled ACK: REQ and ADDR hold, no further events
    ack_dly = 1;
    resp_en = 1'b0;
    begin_run(1'b0, 0, 0);
    seen = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      if (AERIN_REQ) begin seen = 1'b1; break; end
      @(negedge CLK);
    end
    chk("stall req_seen", 32'(seen), 32'd1);
    a0 = AERIN_ADDR;
    stable = 1'b1;
    repeat (50) begin
      @(negedge CLK);
      if (!AERIN_REQ || (AERIN_ADDR !== a0)) stable = 1'b0;
    end
    chk("stall stable", 32'(stable), 32'd1);
    chk("stall events", 32'(got.size() - base_ev), 32'd1);
    resp_en = 1'b1;
    end_run("stall");

    // Reset mid-handshake, then a full run from the seed
    ack_dly = 2;
    begin_run(1'b0, 0, 0);
    seen = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge CLK);
      if ((got.size() - base_ev >= 3) && AERIN_REQ) begin seen = 1'b1; break; end
    end
    chk("midrst req_seen", 32'(seen), 32'd1);
    RST_N = 1'b0;
    #1;
    chk("midrst req",  32'(AERIN_REQ), 32'd0);
    chk("midrst busy", 32'(BUSY),      32'd0);
    chk("midrst cnt",  32'(EVT_CNT),   32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (30) @(negedge CLK);
    mdl_lfsr = SEED;
    begin_run(1'b0, 0, 0);
    end_run("post_rst");

    chk("addr stable during req", 32'(stab_err), 32'd0);
    chk("done with req", 32'(done_req_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
